ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 64 ++++++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two requester ports, the RAM-side port and
//               the busy flag of the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RAM_READ_MODE
`define RAM_READ_MODE 1'b0
`endif
`ifndef RAM_WRITE_MODE
`define RAM_WRITE_MODE 1'b1
`endif

interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester 0
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_ack_o;
  logic              m0_err_o;
  logic [DATA_W-1:0] m0_rdata_o;
  // requester 1
  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_ack_o;
  logic              m1_err_o;
  logic [DATA_W-1:0] m1_rdata_o;
  // RAM side
  logic              ram_mode_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [DATA_W-1:0] ram_data_i;
  logic              busy_o;

  // arbiter view
  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  ram_data_i,
    output m0_ack_o, m0_err_o, m0_rdata_o,
    output m1_ack_o, m1_err_o, m1_rdata_o,
    output ram_mode_o, ram_addr_o, ram_data_o, busy_o
  );

  // requesters plus RAM environment view
  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output ram_data_i,
    input  m0_ack_o, m0_err_o, m0_rdata_o,
    input  m1_ack_o, m1_err_o, m1_rdata_o,
    input  ram_mode_o, ram_addr_o, ram_data_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter giving two requesters shared access to a
//               single-port synchronous RAM. One access per three cycles:
//               IDLE (arbitrate) -> ACCESS (drive RAM) -> RESP (ack).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RAM_READ_MODE
`define RAM_READ_MODE 1'b0
`endif
`ifndef RAM_WRITE_MODE
`define RAM_WRITE_MODE 1'b1
`endif

module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              ptr;        // port favoured when both request
  logic              winner;     // granted port of the current access
  logic              we_q;
  logic              mis_q;      // granted address not word aligned
  logic              mode_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              any_req;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_ok;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer
  always_comb begin
    any_req = bus.m0_req_i | bus.m1_req_i;
    if (bus.m0_req_i && bus.m1_req_i) begin
      grant = ptr;
    end else begin
      grant = bus.m1_req_i;
    end
    sel_we    = grant ? bus.m1_we_i    : bus.m0_we_i;
    sel_addr  = grant ? bus.m1_addr_i  : bus.m0_addr_i;
    sel_wdata = grant ? bus.m1_wdata_i : bus.m0_wdata_i;
  end

  // Access sequencer: capture winner in IDLE, drive RAM in ACCESS, ack in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      winner  <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      mode_q  <= `RAM_READ_MODE;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ACCESS;
            winner  <= grant;
            ptr     <= ~grant;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            mis_q   <= (sel_addr[1:0] != 2'b00);
            // misaligned writes never reach the RAM as writes
            mode_q  <= (sel_we && (sel_addr[1:0] == 2'b00)) ? `RAM_WRITE_MODE
                                                             : `RAM_READ_MODE;
          end
        end
        ACCESS: begin
          state  <= RESP;
          mode_q <= `RAM_READ_MODE;
          ack0_q <= ~winner;
          ack1_q <= winner;
          err_q  <= mis_q;
        end
        RESP: begin
          state  <= IDLE;
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          err_q  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM read data arrives in RESP; only aligned reads pass it through
  assign rd_ok = (state == RESP) && !we_q && !mis_q && !rst;

  assign bus.ram_mode_o = rst ? `RAM_READ_MODE : mode_q;
  assign bus.ram_addr_o = addr_q;
  assign bus.ram_data_o = wdata_q;
  assign bus.busy_o     = !rst && (state != IDLE);

  assign bus.m0_ack_o   = ack0_q & ~rst;
  assign bus.m1_ack_o   = ack1_q & ~rst;
  assign bus.m0_err_o   = ack0_q & err_q & ~rst;
  assign bus.m1_err_o   = ack1_q & err_q & ~rst;
  assign bus.m0_rdata_o = (rd_ok && !winner) ? bus.ram_data_i : '0;
  assign bus.m1_rdata_o = (rd_ok &&  winner) ? bus.ram_data_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with an attached RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack0_seen = 0;
  int ack1_seen = 0;
  int write_seen = 0;

  // Attached RAM: word array, write-first-cycle read of old contents
  logic [31:0] ram [0:63];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 + i;
      ram_ready <= 1'b1;
    end else begin
      if (bus.ram_mode_o == 1'b1) ram[bus.ram_addr_o[7:2]] <= bus.ram_data_o;
      bus.ram_data_i <= ram[bus.ram_addr_o[7:2]];
    end
  end

  // Transaction-level model: age = cycles since grant (-1 = no access)
  int          age = -1;
  logic        m_ptr = 1'b0;
  int          g_w = 0;
  logic        g_we = 1'b0;
  logic        g_mis = 1'b0;
  logic [31:0] g_addr = 32'h0;
  logic [31:0] g_wdata = 32'h0;
  logic [31:0] g_rdata = 32'h0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_data = 32'h0;
  logic [31:0] shadow [0:63];

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 32'hA000_0000 + i;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        age = -1; m_ptr = 1'b0; last_addr = 32'h0; last_data = 32'h0;
      end else if (age == -1) begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          if (bus.m0_req_i && bus.m1_req_i) g_w = int'(m_ptr);
          else g_w = bus.m1_req_i ? 1 : 0;
          m_ptr   = (g_w == 0);
          g_we    = (g_w == 0) ? bus.m0_we_i    : bus.m1_we_i;
          g_addr  = (g_w == 0) ? bus.m0_addr_i  : bus.m1_addr_i;
          g_wdata = (g_w == 0) ? bus.m0_wdata_i : bus.m1_wdata_i;
          g_mis   = (g_addr % 4) != 0;
          last_addr = g_addr;
          last_data = g_wdata;
          age = 1;
        end
      end else if (age == 1) begin
        g_rdata = (!g_we && !g_mis) ? shadow[(g_addr / 4) % 64] : 32'h0;
        if (g_we && !g_mis) shadow[(g_addr / 4) % 64] = g_wdata;
        age = 2;
      end else begin
        age = -1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (bus.m0_ack_o) ack0_seen++;
      if (bus.m1_ack_o) ack1_seen++;
      if (bus.ram_mode_o) write_seen++;
      if (rst) begin
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_mode", bus.ram_mode_o, 0);
        chk("rst_ack0", bus.m0_ack_o, 0);
        chk("rst_ack1", bus.m1_ack_o, 0);
        chk("rst_err", {bus.m0_err_o, bus.m1_err_o}, 0);
        chk("rst_rdata", {bus.m0_rdata_o, bus.m1_rdata_o}, 0);
      end else begin
        chk("busy", bus.busy_o, age != -1);
        chk("mode", bus.ram_mode_o, (age == 1) && g_we && !g_mis);
        chk("ack0", bus.m0_ack_o, (age == 2) && (g_w == 0));
        chk("ack1", bus.m1_ack_o, (age == 2) && (g_w == 1));
        chk("err0", bus.m0_err_o, (age == 2) && (g_w == 0) && g_mis);
        chk("err1", bus.m1_err_o, (age == 2) && (g_w == 1) && g_mis);
        chk("rdata0", bus.m0_rdata_o, ((age == 2) && (g_w == 0)) ? g_rdata : 32'h0);
        chk("rdata1", bus.m1_rdata_o, ((age == 2) && (g_w == 1)) ? g_rdata : 32'h0);
        chk("ram_addr", bus.ram_addr_o, last_addr);
        chk("ram_data", bus.ram_data_o, last_data);
      end
    end
  end

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
    end else begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
    end
  endtask

  task automatic wait_ack(input int port, output int at);
    at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ((port == 0 && bus.m0_ack_o) || (port == 1 && bus.m1_ack_o)) begin
        at = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout: port %0d got no ack expected ack within 12 cycles", port);
  endtask

  task automatic wait_any(output int port, output int at);
    at = -1; port = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.m0_ack_o || bus.m1_ack_o) begin
        at = cyc; port = bus.m1_ack_o ? 1 : 0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL any_ack_timeout: got no ack expected ack within 12 cycles");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int n, at, at2, p, snap;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    do_reset();
    @(negedge clk);
    chk("reset_busy_lit", bus.busy_o, 0);
    chk("reset_addr_lit", bus.ram_addr_o, 0);

    // single write then read on m0
    @(posedge clk); #1;
    drive(0, 1, 1, 32'h8, 32'hDEADBEEF);
    n = cyc;
    wait_ack(0, at);
    chk("t1_latency", at, n + 2);
    chk("t1_err", bus.m0_err_o, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 1, 0, 32'h8, 0);
    wait_ack(0, at);
    chk("t1_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);

    // both ports after reset: alternate 0,1,0,1 every 3 cycles
    do_reset();
    drive(0, 1, 0, 32'h10, 0);
    drive(1, 1, 0, 32'h14, 0);
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_any(p, at);
      chk("t2_port", p, i % 2);
      chk("t2_time", at, n + 2 + 3 * i);
      chk("t2_rdata", (p == 0) ? bus.m0_rdata_o : bus.m1_rdata_o,
          (i % 2 == 0) ? 32'hA000_0004 : 32'hA000_0005);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // misaligned write on m1
    snap = write_seen;
    @(posedge clk); #1 drive(1, 1, 1, 32'h6, 32'h1234);
    wait_ack(1, at);
    chk("t3_err", bus.m1_err_o, 1);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0);
    chk("t3_no_write", write_seen - snap, 0);
    @(posedge clk); #1 drive(1, 1, 0, 32'h4, 0);
    wait_ack(1, at);
    chk("t3_old_data", bus.m1_rdata_o, 32'hA000_0001);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0);

    // reset during ACCESS of an m0 write
    snap = ack0_seen + ack1_seen;
    n = write_seen;
    @(posedge clk); #1 drive(0, 1, 1, 32'hC, 32'h55);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_no_ack", ack0_seen + ack1_seen - snap, 0);
    chk("t4_no_write", write_seen - n, 0);
    drive(0, 1, 0, 32'hC, 0);
    drive(1, 1, 0, 32'h10, 0);
    wait_any(p, at);
    chk("t4_ptr_m0", p, 0);
    chk("t4_old_data", bus.m0_rdata_o, 32'hA000_0003);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    wait_ack(1, at);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0);

    // m1 holds req through its ack
    snap = ack0_seen;
    @(posedge clk); #1 drive(1, 1, 0, 32'h20, 0);
    wait_ack(1, at);
    chk("t5_rdata", bus.m1_rdata_o, 32'hA000_0008);
    wait_ack(1, at2);
    chk("t5_gap", at2 - at, 3);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("t5_no_m0_ack", ack0_seen - snap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
